// File: rtl/mul_seq_pkg.sv
// -----------------------------------------------------------------------------
// mul_seq_pkg
// Shared definitions for the sequential multiplier and the 8-bit ALU it drives:
// ALU opcodes, ALU flag bit positions and the multiplier FSM state type.
// -----------------------------------------------------------------------------
package mul_seq_pkg;

  // ALU opcodes (4-bit). The multiplier only issues ALU_ADD and ALU_CLEAR;
  // the rest are listed so the controller shares one opcode map.
  localparam logic [3:0] ALU_PASS  = 4'b0000;
  localparam logic [3:0] ALU_ADD   = 4'b0001;
  localparam logic [3:0] ALU_SUB   = 4'b0010;
  localparam logic [3:0] ALU_AND   = 4'b0011;
  localparam logic [3:0] ALU_OR    = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_NOT   = 4'b0110;
  localparam logic [3:0] ALU_SHL   = 4'b0111;
  localparam logic [3:0] ALU_SHR   = 4'b1000;
  localparam logic [3:0] ALU_INC   = 4'b1001;
  localparam logic [3:0] ALU_DEC   = 4'b1010;
  localparam logic [3:0] ALU_CLEAR = 4'b1011;

  // Bit positions inside alu_flags = {C, N, Z}.
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  // Number of shift-add iterations for an 8-bit multiplier operand.
  localparam int          MUL_ITERS = 8;
  localparam logic [2:0]  CNT_LAST  = 3'(MUL_ITERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage : mul_seq_pkg

// File: rtl/mul_seq.sv
// -----------------------------------------------------------------------------
// mul_seq
// Sequential 8x8 unsigned shift-add multiplier. Acts as initiator on the shared
// combinational 8-bit ALU: each RUN cycle it issues one ADD of hi and (lo[0] ?
// mcand : 0), takes the 9-bit sum (carry + result) back in the same cycle and
// shifts {carry, sum, lo[7:1]} into {hi, lo}. Eight iterations give the full
// 16-bit product.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   start      in   multiply request, sampled only in IDLE
//   opnd_a     in   [7:0] multiplicand, captured on accept
//   opnd_b     in   [7:0] multiplier, captured on accept
//   busy       out  high while iterating
//   done       out  one-cycle pulse, product valid
//   prod_hi    out  [7:0] product bits 15:8 (held until next accept)
//   prod_lo    out  [7:0] product bits 7:0  (held until next accept)
//   alu_op     out  [3:0] ALU opcode
//   alu_cin    out  ALU carry-in, tied low
//   alu_a      out  [7:0] ALU operand A
//   alu_b      out  [7:0] ALU operand B
//   alu_out    in   [7:0] ALU result
//   alu_flags  in   [2:0] ALU flags {C,N,Z}; only C is used
//
// Build option
//   MUL_SEQ_ZERO_BYPASS_EN : when defined, an accept with a zero operand loads
//   a zero product and goes straight to DONE (done one cycle after accept,
//   busy never rises). When undefined every accept runs all 8 iterations.
//
// State table
//   state | meaning
//   IDLE  | waiting for start; ALU held at CLEAR
//   RUN   | one shift-add iteration per cycle, cnt 0..7
//   DONE  | one-cycle done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module mul_seq
  import mul_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] opnd_a,
  input  logic [7:0] opnd_b,
  output logic       busy,
  output logic       done,
  output logic [7:0] prod_hi,
  output logic [7:0] prod_lo,
  output logic [3:0] alu_op,
  output logic       alu_cin,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  input  logic [2:0] alu_flags
);

  mul_state_t state_q, state_d;

  logic [7:0] mcand;
  logic [7:0] hi;
  logic [7:0] lo;
  logic [2:0] cnt;

  logic       load;
  logic       load_zero;
  logic       step;
  logic       zero_opnd;

  // N and Z are not needed by the multiply; fold them into a sink.
  logic       unused_flags;
  assign unused_flags = ^alu_flags[FLAG_N:FLAG_Z];

  assign zero_opnd = (opnd_a == 8'h00) || (opnd_b == 8'h00);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next state, status outputs and ALU drive
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    load_zero = 1'b0;
    step      = 1'b0;
    alu_op    = ALU_CLEAR;
    alu_a     = 8'h00;
    alu_b     = 8'h00;

    case (state_q)
      IDLE: begin
        if (start) begin
          load = 1'b1;
`ifdef MUL_SEQ_ZERO_BYPASS_EN
          if (zero_opnd) begin
            load_zero = 1'b1;
            state_d   = DONE;
          end else begin
            state_d   = RUN;
          end
`else
          state_d = RUN;
`endif
        end
      end

      RUN: begin
        busy   = 1'b1;
        step   = 1'b1;
        alu_op = ALU_ADD;
        alu_a  = hi;
        alu_b  = lo[0] ? mcand : 8'h00;
        if (cnt == CNT_LAST) state_d = DONE;
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign alu_cin = 1'b0;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand <= 8'h00;
      hi    <= 8'h00;
      lo    <= 8'h00;
      cnt   <= 3'd0;
    end else if (load) begin
      mcand <= opnd_a;
      hi    <= 8'h00;
      lo    <= load_zero ? 8'h00 : opnd_b;
      cnt   <= 3'd0;
    end else if (step) begin
      // 17-bit {carry, sum, lo} shifted right by one; the carry lands in hi[7],
      // so no product bits are lost even for 255*255.
      {hi, lo} <= {alu_flags[FLAG_C], alu_out, lo[7:1]};
      cnt      <= cnt + 3'd1;
    end
  end

  // zero_opnd only matters for the bypass build.
  logic unused_zero;
  assign unused_zero = zero_opnd;

  assign prod_hi = hi;
  assign prod_lo = lo;

endmodule : mul_seq

// File: tb/tb_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_mul_seq
// Directed bench for mul_seq with a behavioural 8-bit ALU attached.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled
// at the same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_mul_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] opnd_a;
  logic [7:0] opnd_b;
  logic       busy;
  logic       done;
  logic [7:0] prod_hi;
  logic [7:0] prod_lo;
  logic [3:0] alu_op;
  logic       alu_cin;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_out;
  logic [2:0] alu_flags;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  mul_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .opnd_a    (opnd_a),
    .opnd_b    (opnd_b),
    .busy      (busy),
    .done      (done),
    .prod_hi   (prod_hi),
    .prod_lo   (prod_lo),
    .alu_op    (alu_op),
    .alu_cin   (alu_cin),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .alu_flags (alu_flags)
  );

  // Behavioural ALU: only ADD and CLEAR matter here, a few others for realism.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum = 9'h000;
    case (alu_op)
      4'b0001: alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
      4'b0000: alu_sum = {1'b0, alu_a};
      4'b0011: alu_sum = {1'b0, alu_a & alu_b};
      4'b0100: alu_sum = {1'b0, alu_a | alu_b};
      4'b0101: alu_sum = {1'b0, alu_a ^ alu_b};
      4'b1011: alu_sum = 9'h000;
      default: alu_sum = 9'h000;
    endcase
    alu_out   = alu_sum[7:0];
    alu_flags = {alu_sum[8], alu_sum[7], (alu_sum[7:0] == 8'h00)};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ALU drive must be CLEAR/0/0 outside RUN and ADD inside RUN; cin always 0.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!busy) chk("alu_idle_drive", {alu_op, alu_a, alu_b}, {4'hB, 8'h00, 8'h00});
      else       chk("alu_run_op", {28'h0, alu_op}, 32'h1);
      chk("alu_cin", {31'h0, alu_cin}, 32'h0);
    end
  end

  // Waits for done starting right after the accepting edge; counts edges and
  // busy cycles seen on the way. Bounded so a stuck DUT still reaches summary.
  task automatic wait_done(output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      tick();
      lat++;
    end
  endtask

  task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input int exp_lat, input int exp_busy);
    int lat, nbusy;
    opnd_a = a;
    opnd_b = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    opnd_a = 8'hxx;
    opnd_b = 8'hxx;
    wait_done(lat, nbusy);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_cycles"}, nbusy, exp_busy);
    chk({tag, "_prod"}, {16'h0, prod_hi, prod_lo}, {16'h0, exp});
    tick();
    chk({tag, "_done_pulse"}, {31'h0, done}, 32'h0);
    chk({tag, "_prod_held"}, {16'h0, prod_hi, prod_lo}, {16'h0, exp});
  endtask

  initial begin
    int lat, nbusy, ndone;
    reset  = 1'b1;
    start  = 1'b0;
    opnd_a = 8'h00;
    opnd_b = 8'h00;
    tick();
    tick();
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_prod", {16'h0, prod_hi, prod_lo}, 32'h0);

    // reset beats start on the same edge
    start  = 1'b1;
    opnd_a = 8'h05;
    opnd_b = 8'h05;
    tick();
    chk("reset_beats_start", {31'h0, busy}, 32'h0);
    start = 1'b0;
    reset = 1'b0;
    mon_en = 1'b1;
    tick();

    run_mul("m13x11",  8'd13,  8'd11,  16'h008F, 8, 8);
    run_mul("m255x255", 8'd255, 8'd255, 16'hFE01, 8, 8);
    run_mul("m1x255",  8'd1,   8'd255, 16'h00FF, 8, 8);
    run_mul("m128x2",  8'd128, 8'd2,   16'h0100, 8, 8);
`ifdef MUL_SEQ_ZERO_BYPASS_EN
    run_mul("m0x5a",   8'd0,   8'h5A,  16'h0000, 0, 0);
    run_mul("m5ax0",   8'h5A,  8'd0,   16'h0000, 0, 0);
`else
    run_mul("m0x5a",   8'd0,   8'h5A,  16'h0000, 8, 8);
    run_mul("m5ax0",   8'h5A,  8'd0,   16'h0000, 8, 8);
`endif

    // start held high through RUN and DONE with new operands
    opnd_a = 8'd6;
    opnd_b = 8'd7;
    start  = 1'b1;
    tick();                       // E0
    opnd_a = 8'd9;
    opnd_b = 8'd9;
    wait_done(lat, nbusy);
    chk("hold_first_latency", lat, 8);
    chk("hold_first_prod", {16'h0, prod_hi, prod_lo}, 32'h002A);
    tick();                       // E9: back to IDLE, start ignored in DONE
    chk("hold_idle_after_done", {30'h0, busy, done}, 32'h0);
    tick();                       // E10: second accept
    chk("hold_second_accept", {31'h0, busy}, 32'h1);
    start = 1'b0;
    wait_done(lat, nbusy);
    chk("hold_second_latency", lat, 8);
    chk("hold_second_prod", {16'h0, prod_hi, prod_lo}, 32'h0051);
    tick();

    // reset in the middle of RUN aborts without a done pulse
    opnd_a = 8'd200;
    opnd_b = 8'd3;
    start  = 1'b1;
    tick();                       // E0
    start  = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_busy_before", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_prod", {16'h0, prod_hi, prod_lo}, 32'h0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_mul("m200x3", 8'd200, 8'd3, 16'h0258, 8, 8);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule : tb_mul_seq
